// File: rtl/sipo_word_assembler.sv
// sipo_word_assembler: collects a serial bit stream into WIDTH-bit words and
// presents each finished word on a registered, double-buffered parallel bus.
// Optional build macro: SIPO_WORD_ASSEMBLER_PARITY_EN. When it is defined, each
// frame carries one extra even-parity bit after the data bits, and out_perr
// flags a parity mismatch on the word it accompanies.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. That applies to ser_valid/ser_ready and to out_valid/out_ready. While
// out_valid is high and out_ready is low, out_data and out_perr hold steady.
// out_ready is ignored while out_valid is low.
module sipo_word_assembler #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         ser_in,
  input  logic                         ser_valid,
  output logic                         ser_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_perr,
  output logic [$clog2(WIDTH+1)-1:0]   bit_cnt
);

  localparam int CW = $clog2(WIDTH + 1);
`ifdef SIPO_WORD_ASSEMBLER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  // Output register occupancy; out_valid is the registered copy of this state.
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
  state_t state;

  logic [WIDTH-1:0] collect;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] word_next;
  logic             perr_next;
  logic             at_last;
  logic             accept;
  logic             complete;

  // Only the frame-completing bit can stall, and only when the held word is
  // not being drained on the same edge.
  assign at_last   = (bit_cnt == LAST);
  assign ser_ready = !(at_last && out_valid && !out_ready);
  // clear wins over a simultaneous bit: that bit is dropped.
  assign accept    = ser_valid && ser_ready && !clear;
  assign complete  = accept && at_last;

  // Collect register with the incoming bit folded in at the end that fits the
  // bit order.
  assign shifted = MSB_FIRST ? {collect[WIDTH-2:0], ser_in}
                             : {ser_in, collect[WIDTH-1:1]};

`ifdef SIPO_WORD_ASSEMBLER_PARITY_EN
  // The final bit is the parity bit: data is already complete in collect.
  assign word_next = collect;
  assign perr_next = (^collect) ^ ser_in;
`else
  // The final bit is a data bit and belongs in the delivered word.
  assign word_next = shifted;
  assign perr_next = 1'b0;
`endif

  // Serial collection: shift accepted bits in and count them per frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      collect <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      collect <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      if (complete) begin
        collect <= '0;
        bit_cnt <= '0;
      end else begin
        collect <= shifted;
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  // Output FSM: load on completion (even while FULL and draining), empty on
  // a consume that is not replaced by a new word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_perr  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (complete) begin
            state     <= FULL;
            out_valid <= 1'b1;
            out_data  <= word_next;
            out_perr  <= perr_next;
          end
        end
        FULL: begin
          if (complete) begin
            state     <= FULL;
            out_valid <= 1'b1;
            out_data  <= word_next;
            out_perr  <= perr_next;
          end else if (out_ready) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_word_assembler.sv
// tb_sipo_word_assembler: drives one serial stream into two assemblers (MSB
// first and LSB first) and checks both against a queue-based frame model on
// every cycle, plus literal expectations for the directed words.
module tb_sipo_word_assembler;

  localparam int WIDTH = 4;
  localparam int CW    = $clog2(WIDTH + 1);
`ifdef SIPO_WORD_ASSEMBLER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic clear = 1'b0;
  logic ser_in = 1'b0;
  logic ser_valid = 1'b0;
  logic out_ready = 1'b0;

  logic             m_ser_ready, l_ser_ready;
  logic [WIDTH-1:0] m_out_data, l_out_data;
  logic             m_out_valid, l_out_valid;
  logic             m_out_perr, l_out_perr;
  logic [CW-1:0]    m_bit_cnt, l_bit_cnt;

  sipo_word_assembler #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .clear(clear), .ser_in(ser_in), .ser_valid(ser_valid),
    .ser_ready(m_ser_ready), .out_data(m_out_data), .out_valid(m_out_valid),
    .out_ready(out_ready), .out_perr(m_out_perr), .bit_cnt(m_bit_cnt)
  );

  sipo_word_assembler #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .clear(clear), .ser_in(ser_in), .ser_valid(ser_valid),
    .ser_ready(l_ser_ready), .out_data(l_out_data), .out_valid(l_out_valid),
    .out_ready(out_ready), .out_perr(l_out_perr), .bit_cnt(l_bit_cnt)
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Pending frame bits in arrival order; a word is formed when FRAME arrive.
  int               mbits[$];
  logic             md_valid = 1'b0;
  logic [WIDTH-1:0] md_msb = '0;
  logic [WIDTH-1:0] md_lsb = '0;
  logic             md_perr = 1'b0;

  function automatic logic model_ready();
    return !((mbits.size() == FRAME - 1) && md_valid && !out_ready);
  endfunction

  always @(posedge clk or posedge rst) begin
    logic done;
    logic p;
    done = 1'b0;
    if (rst) begin
      mbits.delete();
      md_valid = 1'b0;
      md_msb = '0;
      md_lsb = '0;
      md_perr = 1'b0;
    end else begin
      if (clear) begin
        mbits.delete();
      end else if (ser_valid && model_ready()) begin
        mbits.push_back(int'(ser_in));
        if (mbits.size() == FRAME) begin
          p = 1'b0;
          for (int i = 0; i < WIDTH; i++) begin
            md_msb[WIDTH-1-i] = (mbits[i] != 0);
            md_lsb[i]         = (mbits[i] != 0);
          end
          for (int i = 0; i < FRAME; i++) p = p ^ (mbits[i] != 0);
          md_perr = (FRAME > WIDTH) ? p : 1'b0;
          mbits.delete();
          done = 1'b1;
        end
      end
      if (done) md_valid = 1'b1;
      else if (md_valid && out_ready) md_valid = 1'b0;
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("msb_valid", 32'(m_out_valid), 32'(md_valid));
    chk("lsb_valid", 32'(l_out_valid), 32'(md_valid));
    chk("msb_data", 32'(m_out_data), 32'(md_msb));
    chk("lsb_data", 32'(l_out_data), 32'(md_lsb));
    chk("msb_perr", 32'(m_out_perr), 32'(md_perr));
    chk("lsb_perr", 32'(l_out_perr), 32'(md_perr));
    chk("msb_bit_cnt", 32'(m_bit_cnt), 32'(mbits.size()));
    chk("lsb_bit_cnt", 32'(l_bit_cnt), 32'(mbits.size()));
    chk("msb_ser_ready", 32'(m_ser_ready), 32'(model_ready()));
    chk("lsb_ser_ready", 32'(l_ser_ready), 32'(model_ready()));
  end

  // ---------------- driver tasks ----------------
  // Present one bit and hold it until accepted (bounded).
  task automatic send_bit(input logic b);
    logic r;
    int n;
    ser_in = b;
    ser_valid = 1'b1;
    n = 0;
    r = 1'b0;
    while (!r && n < 50) begin
      @(negedge clk) r = m_ser_ready;
      @(posedge clk) #1;
      n++;
    end
    if (!r) chk("send_bit_timeout", 32'd0, 32'd1);
    ser_valid = 1'b0;
  endtask

  // Frame bits for a word written in transmit order (leftmost sent first),
  // with the even-parity bit in slot WIDTH.
  task automatic make_seq(input logic [WIDTH-1:0] w, output logic seq [0:WIDTH]);
    for (int i = 0; i < WIDTH; i++) seq[i] = w[WIDTH-1-i];
    seq[WIDTH] = ^w;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w);
    logic seq [0:WIDTH];
    make_seq(w, seq);
    for (int i = 0; i < FRAME; i++) send_bit(seq[i]);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk) #1;
    out_ready = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic seq [0:WIDTH];

    // 1. reset then idle
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(m_out_valid), 32'd0);
    chk("rst_data", 32'(m_out_data), 32'd0);
    chk("rst_ready", 32'(m_ser_ready), 32'd1);
    chk("rst_bit_cnt", 32'(m_bit_cnt), 32'd0);
    @(posedge clk) #1;

    // 2. single word 1,1,0,1, held 5 cycles, then consumed
    send_word(4'b1101);
    chk("w1_valid", 32'(m_out_valid), 32'd1);
    chk("w1_msb", 32'(m_out_data), 32'h0000000d);
    chk("w1_lsb", 32'(l_out_data), 32'h0000000b);
    repeat (5) @(posedge clk);
    #1 chk("w1_hold", 32'(m_out_data), 32'h0000000d);
    consume();
    chk("w1_consumed", 32'(m_out_valid), 32'd0);

    // 3. backpressure: word held, final bit of 0,1,0,0 stalls
    send_word(4'b1111);
    make_seq(4'b0100, seq);
    for (int i = 0; i < FRAME - 1; i++) send_bit(seq[i]);
    ser_in = seq[FRAME-1];
    ser_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("bp_ready_low", 32'(m_ser_ready), 32'd0);
    chk("bp_bit_cnt", 32'(m_bit_cnt), 32'(FRAME - 1));
    chk("bp_old_word", 32'(m_out_data), 32'h0000000f);
    @(posedge clk) #1 out_ready = 1'b1;
    @(posedge clk) #1;
    out_ready = 1'b0;
    ser_valid = 1'b0;
    chk("bp_msb", 32'(m_out_data), 32'h00000004);
    chk("bp_lsb", 32'(l_out_data), 32'h00000002);
    chk("bp_valid", 32'(m_out_valid), 32'd1);

    // 4. consume and complete on the same edge, word 1,0,1,0
    make_seq(4'b1010, seq);
    for (int i = 0; i < FRAME - 1; i++) send_bit(seq[i]);
    ser_in = seq[FRAME-1];
    ser_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk) #1;
    ser_valid = 1'b0;
    out_ready = 1'b0;
    chk("sim_msb", 32'(m_out_data), 32'h0000000a);
    chk("sim_lsb", 32'(l_out_data), 32'h00000005);
    chk("sim_valid", 32'(m_out_valid), 32'd1);
    consume();

    // 5. clear mid-word drops the partial and the coincident bit
    send_bit(1'b1);
    send_bit(1'b1);
    clear = 1'b1;
    ser_valid = 1'b1;
    ser_in = 1'b1;
    @(posedge clk) #1;
    clear = 1'b0;
    ser_valid = 1'b0;
    chk("clr_bit_cnt", 32'(m_bit_cnt), 32'd0);
    chk("clr_valid", 32'(m_out_valid), 32'd0);
    send_word(4'b0011);
    chk("clr_msb", 32'(m_out_data), 32'h00000003);
    chk("clr_lsb", 32'(l_out_data), 32'h0000000c);
    consume();

`ifdef SIPO_WORD_ASSEMBLER_PARITY_EN
    // 6. parity: correct parity bit, then a wrong one
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    chk("par_ok_data", 32'(m_out_data), 32'h0000000d);
    chk("par_ok_perr", 32'(m_out_perr), 32'd0);
    consume();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    chk("par_bad_data", 32'(m_out_data), 32'h0000000d);
    chk("par_bad_perr", 32'(m_out_perr), 32'd1);
    chk("par_bad_perr_lsb", 32'(l_out_perr), 32'd1);
`else
    chk("noparity_perr", 32'(m_out_perr), 32'd0);
    send_word(4'b1001);
`endif

    // async reset mid-frame with a word held
    send_bit(1'b1);
    send_bit(1'b0);
    @(posedge clk) #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(m_out_valid), 32'd0);
    chk("arst_data", 32'(m_out_data), 32'd0);
    chk("arst_perr", 32'(m_out_perr), 32'd0);
    chk("arst_bit_cnt", 32'(m_bit_cnt), 32'd0);
    @(posedge clk) #1 rst = 1'b0;

    // one more word after reset to show recovery
    send_word(4'b0110);
    chk("post_msb", 32'(m_out_data), 32'h00000006);
    consume();
    repeat (2) @(posedge clk);

    #1 $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sipo_word_assembler.md
Name: sipo_word_assembler

Overview:
- Serial-to-parallel front end that sits directly upstream of the 4-bit PIPO shift register stage.
- Collects a serial bit stream into WIDTH-bit words and presents each finished word on a registered parallel bus, using a valid/ready handshake.
- Holds one finished word while the next word is being collected (double buffered).
- Back-pressures the serial side only when a new word would complete while the output register is still occupied.

Parameters:
- WIDTH, 4, bits per assembled word (legal values 2..16).
- MSB_FIRST, 1, 1 = first received bit lands in bit WIDTH-1; 0 = first received bit lands in bit 0.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous; discards the partially collected word.
- ser_in  input  1  serial data bit.
- ser_valid  input  1  ser_in is valid this cycle.
- ser_ready  output  1  block accepts ser_in this cycle.
- out_data  output  WIDTH  assembled word; feeds the PIPO parallel_in.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  downstream consumes out_data this cycle.
- out_perr  output  1  parity error flag accompanying out_data.
- bit_cnt  output  $clog2(WIDTH+1)  number of bits currently collected (debug).

Behaviour:
- Reset (async assert, sync release): out_data=0, out_valid=0, out_perr=0, bit_cnt=0, collect register=0. ser_ready=1 after reset.
- Bit accept:
  - A bit is accepted when ser_valid && ser_ready at a rising edge.
  - With MSB_FIRST=1 the collect register shifts left and ser_in enters at bit 0. With MSB_FIRST=0 it shifts right and ser_in enters at bit WIDTH-1.
  - bit_cnt increments on each accepted bit.
- Word completion:
  - The accept that brings bit_cnt to FRAME (FRAME = WIDTH, or WIDTH+1 with parity) loads the collect register into out_data.
  - The same edge sets out_valid=1 and resets bit_cnt to 0.
  - Latency: out_valid is high the cycle after the final bit is accepted.
- Output FSM, two states:
  - EMPTY (out_valid=0) -> FULL when a word completes.
  - FULL -> EMPTY when out_ready=1 and no word completes in the same cycle.
  - FULL stays FULL when out_ready=1 and a word completes in the same cycle. The new word replaces out_data; no bubble and no loss.
- ser_ready = !(bit_cnt==FRAME-1 && out_valid && !out_ready).
  - Ready is combinational from out_ready.
  - Bits that do not complete a word are always accepted.
- out_data and out_perr are stable while out_valid=1 && out_ready=0.
- out_ready while out_valid=0 is ignored.
- clear:
  - Sets bit_cnt=0 and the collect register to 0.
  - Does not touch out_data or out_valid.
  - clear has priority over a simultaneous bit accept; that bit is dropped.
- rst mid-word or mid-handshake: all state cleared immediately, held word lost.
- bit_cnt never exceeds FRAME-1 in a registered state.

Optional Feature:
- Macro: SIPO_WORD_ASSEMBLER_PARITY_EN.
- Defined:
  - FRAME = WIDTH+1; the last serial bit of each frame is an even-parity bit over the WIDTH data bits and is not stored in out_data.
  - out_perr is loaded with (XOR of data bits) ^ parity_bit when the word completes. The word is still delivered.
- Not defined:
  - FRAME = WIDTH, and out_perr is constant 0.
  - Port list is identical in both builds.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, release -> out_valid=0, out_data=0, ser_ready=1, bit_cnt=0.
2. Single word, MSB_FIRST=1, WIDTH=4: send 1,1,0,1 on consecutive cycles with out_ready=0 -> out_data=4'b1101 and out_valid=1 one cycle after the 4th bit. Value holds for 5 cycles; out_ready=1 for one cycle -> out_valid=0.
3. Backpressure: out_valid=1 with out_ready=0, send 0,1,0 then present a 4th bit 0 -> ser_ready=0 and bit_cnt=3 hold. Raise out_ready -> 4th bit accepted, out_data=4'b0100, out_valid stays 1.
4. Simultaneous consume and complete: out_ready=1 on the same edge the 4th bit of 1,0,1,0 is accepted -> out_data=4'b1010 next cycle, out_valid continuously 1.
5. clear mid-word: send 1,1, then clear=1 with ser_valid=1, ser_in=1 -> bit_cnt=0. Then send 0,0,1,1 -> out_data=4'b0011.
6. Parity build: send 1,1,0,1 then parity bit 1 -> out_data=4'b1101, out_perr=0. Repeat with parity bit 0 -> out_perr=1. Async rst pulsed mid-frame -> all outputs 0 within the same cycle.
